// File: rtl/ticket_pkg.sv
// Shared types and fare constants for the ticket vending sequencer.
package ticket_pkg;

    localparam int FW = 4;

    localparam logic [FW-1:0] PRICE0_DEF = 4'd3;
    localparam logic [FW-1:0] PRICE1_DEF = 4'd7;
    localparam logic [FW-1:0] PRICE2_DEF = 4'd10;
    localparam logic [FW-1:0] PRICE3_DEF = 4'd12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_e;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        full_add = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/ticket_vend_ctrl_sub4.sv
// 4-bit ripple subtractor d = a - b; cout=1 means no borrow (a >= b).
module sub4
    import ticket_pkg::*;
(
    input  logic [FW-1:0] a,
    input  logic [FW-1:0] b,
    output logic [FW-1:0] d,
    output logic          cout
);

    logic [FW-1:0] b_inv_s;
    logic [1:0]    cell_s;
    logic          carry_s;

    assign b_inv_s = ~b;

    // Ripple the carry through one full-adder cell per bit, carry-in tied high.
    always_comb begin
        carry_s = 1'b1;
        d       = {FW{1'b0}};
        cell_s  = 2'b00;
        for (int i = 0; i < FW; i++) begin
            cell_s  = full_add(a[i], b_inv_s[i], carry_s);
            d[i]    = cell_s[0];
            carry_s = cell_s[1];
        end
        cout = carry_s;
    end

endmodule

// File: rtl/ticket_vend_ctrl.sv
// Ticket seller sequencer: fare latch, coin credit, vend decision, change payout and
// active-low balance LEDs. One subtractor is shared between fare compare and payout.
module ticket_vend_ctrl
    import ticket_pkg::*;
#(
    parameter logic [FW-1:0] PRICE0 = PRICE0_DEF,
    parameter logic [FW-1:0] PRICE1 = PRICE1_DEF,
    parameter logic [FW-1:0] PRICE2 = PRICE2_DEF,
    parameter logic [FW-1:0] PRICE3 = PRICE3_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_valid,
    input  logic [1:0] price_sel,
    input  logic       coin_valid,
    input  logic [3:0] coin_val,
    input  logic       cancel,
    output logic       busy,
    output logic       coin_rej,
    output logic       ticket,
    output logic       change_pulse,
    output logic [4:0] led
);

    state_e        state_q, state_d;
    logic [FW-1:0] credit_q, credit_d;
    logic [FW-1:0] fare_q, fare_d;

    logic [FW-1:0] sub_b_s;
    logic [FW-1:0] sub_d_s;
    logic          sub_cout_s;
    logic          enough_s;
    logic          coin_s;
    logic [FW:0]   coin_sum_s;
    logic [FW-1:0] price_s;

    // Operand select; the decrement is withheld at zero so credit can never wrap.
    always_comb begin
        case (state_q)
            COLLECT: sub_b_s = fare_q;
            VEND:    sub_b_s = fare_q;
            REFUND:  sub_b_s = (credit_q != 4'd0) ? 4'd1 : 4'd0;
            default: sub_b_s = 4'd0;
        endcase
    end

    sub4 u_sub4 (
        .a    (credit_q),
        .b    (sub_b_s),
        .d    (sub_d_s),
        .cout (sub_cout_s)
    );

    assign enough_s   = (state_q == COLLECT) & sub_cout_s;
    assign coin_s     = coin_valid & (coin_val != 4'd0);
    assign coin_sum_s = {1'b0, credit_q} + {1'b0, coin_val};

    // Fare lookup for the selection strobe.
    always_comb begin
        case (price_sel)
            2'd0:    price_s = PRICE0;
            2'd1:    price_s = PRICE1;
            2'd2:    price_s = PRICE2;
            2'd3:    price_s = PRICE3;
            default: price_s = PRICE0;
        endcase
    end

    // Next-state, credit update and the per-cycle pulse outputs.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        fare_d       = fare_q;
        coin_rej     = 1'b0;
        ticket       = 1'b0;
        change_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                coin_rej = coin_s;
                if (sel_valid) begin
                    fare_d  = price_s;
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (enough_s) begin
                    coin_rej = coin_s;
                    state_d  = VEND;
                end else if (cancel) begin
                    coin_rej = coin_s;
                    state_d  = REFUND;
                end else if (coin_s) begin
                    if (coin_sum_s <= 5'd15) begin
                        credit_d = coin_sum_s[FW-1:0];
                    end else begin
                        coin_rej = 1'b1;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            VEND: begin
                ticket   = 1'b1;
                coin_rej = coin_s;
                credit_d = sub_d_s;
                state_d  = REFUND;
            end
            REFUND: begin
                coin_rej = coin_s;
                if (credit_q != 4'd0) begin
                    change_pulse = 1'b1;
                    credit_d     = sub_d_s;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, credit and fare registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= 4'd0;
            fare_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            fare_q   <= fare_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign led  = {~enough_s, ~credit_q};

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Scoreboard bench for ticket_vend_ctrl: a cycle model pushes expected outputs, a monitor pops and compares.
module tb_ticket_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_valid = 1'b0;
    logic [1:0] price_sel = 2'd0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_val = 4'd0;
    logic       cancel = 1'b0;
    logic       busy, coin_rej, ticket, change_pulse;
    logic [4:0] led;

    int total = 0;
    int bad = 0;
    int n_tick = 0;
    int n_chg = 0;
    int n_rej = 0;

    ticket_vend_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sel_valid    (sel_valid),
        .price_sel    (price_sel),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .cancel       (cancel),
        .busy         (busy),
        .coin_rej     (coin_rej),
        .ticket       (ticket),
        .change_pulse (change_pulse),
        .led          (led)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       rej;
        logic       tick;
        logic       chg;
        logic [4:0] led;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a sale is a phase plus integer credit and fare.
    localparam int PH_IDLE = 0, PH_PAY = 1, PH_ISSUE = 2, PH_RETURN = 3;
    int m_phase = PH_IDLE, m_credit = 0, m_fare = 0;
    int n_phase, n_credit, n_fare;
    int fares[4] = '{3, 7, 10, 12};

    always @(negedge clk) begin
        exp_t e;
        bit   cv, enough;
        logic [3:0] cr;
        cv       = coin_valid && (coin_val != 4'd0);
        enough   = (m_phase == PH_PAY) && (m_credit >= m_fare);
        n_phase  = m_phase;
        n_credit = m_credit;
        n_fare   = m_fare;
        e        = '0;
        e.busy   = (m_phase != PH_IDLE);
        cr       = m_credit[3:0];
        e.led    = {~enough, ~cr};
        if (m_phase == PH_IDLE) begin
            e.rej = cv;
            if (sel_valid) begin
                n_fare  = fares[price_sel];
                n_phase = PH_PAY;
            end
        end else if (m_phase == PH_PAY) begin
            if (enough) begin
                e.rej = cv; n_phase = PH_ISSUE;
            end else if (cancel) begin
                e.rej = cv; n_phase = PH_RETURN;
            end else if (cv) begin
                if (m_credit + int'(coin_val) <= 15) n_credit = m_credit + int'(coin_val);
                else e.rej = 1'b1;
            end
        end else if (m_phase == PH_ISSUE) begin
            e.tick = 1'b1; e.rej = cv;
            n_credit = m_credit - m_fare;
            n_phase = PH_RETURN;
        end else begin
            e.rej = cv;
            if (m_credit > 0) begin
                e.chg = 1'b1; n_credit = m_credit - 1;
            end else begin
                n_phase = PH_IDLE;
            end
        end
        exp_q.push_back(e);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = PH_IDLE; m_credit = 0; m_fare = 0;
        end else begin
            m_phase = n_phase; m_credit = n_credit; m_fare = n_fare;
        end
    end

    // Monitor: pop one expectation per cycle and compare every output.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (ticket) n_tick++;
        if (change_pulse) n_chg++;
        if (coin_rej) n_rej++;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: actual=0 entries required=1 entry");
        end else begin
            e = exp_q.pop_front();
            if (busy !== e.busy) begin bad++; $display("FAIL busy @%0t: actual=%b required=%b", $time, busy, e.busy); end
            total++;
            if (coin_rej !== e.rej) begin bad++; $display("FAIL coin_rej @%0t: actual=%b required=%b", $time, coin_rej, e.rej); end
            total++;
            if (ticket !== e.tick) begin bad++; $display("FAIL ticket @%0t: actual=%b required=%b", $time, ticket, e.tick); end
            total++;
            if (change_pulse !== e.chg) begin bad++; $display("FAIL change_pulse @%0t: actual=%b required=%b", $time, change_pulse, e.chg); end
            total++;
            if (led !== e.led) begin bad++; $display("FAIL led @%0t: actual=%b required=%b", $time, led, e.led); end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_sel(input logic [1:0] s);
        sel_valid = 1'b1; price_sel = s;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_coin(input logic [3:0] v);
        coin_valid = 1'b1; coin_val = v;
        tick();
        coin_valid = 1'b0; coin_val = 4'd0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            tick();
        end
        check({name, "_idle"}, int'(busy), 0);
    endtask

    task automatic clear_counts();
        n_tick = 0; n_chg = 0; n_rej = 0;
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_led", int'(led), 31);

        // T1: fare 7, coins 5+5, change 3
        clear_counts();
        do_sel(2'd1); do_coin(4'd5); do_coin(4'd5);
        check("t1_led", int'(led), 5);
        wait_idle("t1");
        check("t1_ticket", n_tick, 1);
        check("t1_change", n_chg, 3);

        // T2: exact fare 3
        clear_counts();
        do_sel(2'd0); do_coin(4'd3);
        wait_idle("t2");
        check("t2_ticket", n_tick, 1);
        check("t2_change", n_chg, 0);

        // T3: overflow coin rejected
        clear_counts();
        do_sel(2'd3); do_coin(4'd9); do_coin(4'd9);
        check("t3_credit_led", int'(led[3:0]), 6);
        do_coin(4'd3);
        wait_idle("t3");
        check("t3_rej", n_rej, 1);
        check("t3_ticket", n_tick, 1);
        check("t3_change", n_chg, 0);

        // T4: cancel with coin
        clear_counts();
        do_sel(2'd2); do_coin(4'd4);
        cancel = 1'b1; coin_valid = 1'b1; coin_val = 4'd2;
        tick();
        cancel = 1'b0; coin_valid = 1'b0; coin_val = 4'd0;
        wait_idle("t4");
        check("t4_rej", n_rej, 1);
        check("t4_ticket", n_tick, 0);
        check("t4_change", n_chg, 4);

        // T5: enough wins over cancel
        clear_counts();
        do_sel(2'd1); do_coin(4'd8);
        cancel = 1'b1; coin_valid = 1'b1; coin_val = 4'd1;
        tick();
        cancel = 1'b0; coin_valid = 1'b0; coin_val = 4'd0;
        wait_idle("t5");
        check("t5_rej", n_rej, 1);
        check("t5_ticket", n_tick, 1);
        check("t5_change", n_chg, 1);

        // T6: reset during payout
        clear_counts();
        do_sel(2'd0); do_coin(4'd7);
        for (int i = 0; i < 20; i++) begin
            if (n_chg == 2) break;
            tick();
        end
        check("t6_reach", n_chg, 2);
        rst = 1'b1;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_led", int'(led), 31);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("t6_no_pulse", n_chg, 2);
        clear_counts();
        do_coin(4'd5);
        check("t6_idle_rej", n_rej, 1);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 79) == 0);
            sel_valid  = ($urandom_range(0, 3) == 0);
            price_sel  = 2'($urandom_range(0, 3));
            coin_valid = ($urandom_range(0, 1) == 0);
            coin_val   = 4'($urandom_range(0, 15));
            cancel     = ($urandom_range(0, 11) == 0);
            tick();
        end
        rst = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_val = 4'd0; cancel = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
